// File: rtl/sync_fifo_if.sv
// Handshake/status bundle for sync_fifo: the master drives requests, the slave (FIFO) drives data and status.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_WIDTH-1:0]  fill_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  data_out, fifo_full, fifo_empty, almost_full, almost_empty,
           fill_count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output data_out, fifo_full, fifo_empty, almost_full, almost_empty,
           fill_count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO of arbitrary depth with fill count, thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  sync_fifo_if.slave bus
);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);
  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_fill_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [PTR_WIDTH-1:0]  w_wr_ptr_inc;
  logic [PTR_WIDTH-1:0]  w_rd_ptr_inc;

  assign w_empty  = (r_fill_count == '0);
  assign w_full   = (r_fill_count == CNT_WIDTH'(DEPTH));
  assign w_rd_acc = bus.rd_en && !w_empty;
  // A full FIFO still takes a write when the same cycle frees a slot.
  assign w_wr_acc = bus.wr_en && (!w_full || w_rd_acc);

  assign w_wr_ptr_inc = (r_wr_ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_inc = (r_rd_ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill_count <= '0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= w_wr_ptr_inc;
      if (w_rd_acc) r_rd_ptr <= w_rd_ptr_inc;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_fill_count <= r_fill_count + 1'b1;
        2'b01:   r_fill_count <= r_fill_count - 1'b1;
        default: r_fill_count <= r_fill_count;
      endcase
      // A new error in the same cycle as clr_err takes precedence.
      r_overflow  <= (bus.wr_en && !w_wr_acc) || (r_overflow  && !bus.clr_err);
      r_underflow <= (bus.rd_en && !w_rd_acc) || (r_underflow && !bus.clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= bus.data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.data_out = r_mem[r_rd_ptr];
`else
  logic [DATA_WIDTH-1:0] r_data_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
    end else if (w_rd_acc) begin
      r_data_out <= r_mem[r_rd_ptr];
    end
  end

  assign bus.data_out = r_data_out;
`endif

  assign bus.fill_count   = r_fill_count;
  assign bus.fifo_empty   = w_empty;
  assign bus.fifo_full    = w_full;
  assign bus.almost_full  = (r_fill_count >= CNT_WIDTH'(AF_LEVEL));
  assign bus.almost_empty = (r_fill_count <= CNT_WIDTH'(AE_LEVEL));
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=6, AF=5, AE=1) with a data scoreboard and a reference occupancy/flag model.
module tb_sync_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 6;
  localparam int AF    = 5;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  sync_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .AF_LEVEL  (AF),
    .AE_LEVEL  (AE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] sb[$];
  int            m_cnt = 0;
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string ctx);
    chk({ctx, ":fill_count"},   32'(bus.fill_count),   32'(m_cnt));
    chk({ctx, ":fifo_empty"},   32'(bus.fifo_empty),   32'(m_cnt == 0));
    chk({ctx, ":fifo_full"},    32'(bus.fifo_full),    32'(m_cnt == DEPTH));
    chk({ctx, ":almost_full"},  32'(bus.almost_full),  32'(m_cnt >= AF));
    chk({ctx, ":almost_empty"}, 32'(bus.almost_empty), 32'(m_cnt <= AE));
    chk({ctx, ":overflow"},     32'(bus.overflow),     32'(m_ovf));
    chk({ctx, ":underflow"},    32'(bus.underflow),    32'(m_udf));
  endtask

  task automatic reset_model();
    sb.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic chk_reset(input string ctx);
    chk_status(ctx);
`ifndef SYNC_FIFO_FWFT_EN
    chk({ctx, ":data_out"}, 32'(bus.data_out), 32'h0);
`endif
  endtask

  // One clock of stimulus; the model decides acceptance from its own occupancy.
  task automatic cycle(input string ctx, input bit wr, input logic [DW-1:0] din,
                       input bit rd, input bit clr);
    bit            ra;
    bit            wa;
    logic [DW-1:0] exp_d;
    bus.wr_en   = wr;
    bus.data_in = din;
    bus.rd_en   = rd;
    bus.clr_err = clr;
    ra    = rd && (m_cnt != 0);
    wa    = wr && ((m_cnt != DEPTH) || ra);
    exp_d = '0;
    @(posedge clk);
    #1;
    m_ovf = (wr && !wa) || (m_ovf && !clr);
    m_udf = (rd && !ra) || (m_udf && !clr);
    if (ra) begin
      exp_d = sb.pop_front();
      m_cnt--;
`ifndef SYNC_FIFO_FWFT_EN
      chk({ctx, ":rd_data"}, 32'(bus.data_out), 32'(exp_d));
`endif
    end
    if (wa) begin
      sb.push_back(din);
      m_cnt++;
    end
`ifdef SYNC_FIFO_FWFT_EN
    if (m_cnt != 0) chk({ctx, ":fwft_head"}, 32'(bus.data_out), 32'(sb[0]));
`endif
    $display("%-10s wr=%0d din=%02h rd=%0d clr=%0d | wacc=%0d racc=%0d exp_rd=%02h dout=%02h cnt=%0d ovf=%0d udf=%0d",
             ctx, wr, din, rd, clr, wa, ra, exp_d, bus.data_out, bus.fill_count,
             bus.overflow, bus.underflow);
    chk_status(ctx);
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.data_in = '0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;

    // Reset state
    #12;
    chk_reset("reset");
    rst_n = 1'b1;

    // Fill 0x11..0x16, then a rejected write
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
    cycle("ovf_wr", 1'b1, 8'hAA, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("clr_ovf", 1'b0, 8'h00, 1'b0, 1'b1);

    // Interleaved traffic wrapping both pointers several times
    for (int i = 0; i < 20; i++) cycle("wrap", 1'b1, 8'(8'h30 + i), (i > 0), 1'b0);
    cycle("wrap_end", 1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous read+write on a full FIFO
    for (int i = 0; i < DEPTH; i++) cycle("fill2", 1'b1, 8'(8'h51 + i), 1'b0, 1'b0);
    cycle("full_rw", 1'b1, 8'h77, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous read+write on an empty FIFO, clear, then set-beats-clear
    cycle("empty_rw", 1'b1, 8'h42, 1'b1, 1'b0);
    cycle("clr_udf", 1'b0, 8'h00, 1'b0, 1'b1);
    cycle("rd_42", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("udf_clr", 1'b0, 8'h00, 1'b1, 1'b1);
    cycle("clr_all", 1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset with data in flight
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 8'(8'hC1 + i), 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    reset_model();
    chk_reset("async_rst");
    #2;
    rst_n = 1'b1;

    // First write after reset lands at address 0 and reads back
    cycle("post_wr", 1'b1, 8'h99, 1'b0, 1'b0);
    cycle("post_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
